codificador_bcd_seq: RTL and testbench

Multi-digit, mode-selectable BCD code converter with valid/ready handshakes on input and output. It accepts a packed word of DIGITS BCD digits and converts one digit per clock. Selectable target codes are Excess-3, Gray, Aiken 2421 and passthrough. Each out-of-range digit is flagged. It sits between digit-entry logic and display/transmission stages, replacing single-digit purely combinational converters.

---
 rtl/codificador_pkg.sv | 21 ++
 rtl/codificador_bcd_seq_if.sv | 29 ++
 rtl/codificador_digito.sv | 27 ++
 rtl/codificador_bcd_seq.sv | 127 ++++++++++++
 tb/tb_codificador_bcd_seq.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/codificador_pkg.sv
// Shared constants for the sequential BCD code converter: mode encodings,
// FSM state encoding, digit width and the fill value for invalid digits.
package codificador_pkg;

  localparam int unsigned DIGIT_W = 4;
  localparam int unsigned MODE_W  = 2;

  localparam logic [MODE_W-1:0] MODE_XS3  = 2'd0;
  localparam logic [MODE_W-1:0] MODE_GRAY = 2'd1;
  localparam logic [MODE_W-1:0] MODE_2421 = 2'd2;
  localparam logic [MODE_W-1:0] MODE_PASS = 2'd3;

  localparam logic [DIGIT_W-1:0] INVALID_FILL = 4'h0;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CONVERT = 2'd1,
    S_HOLD    = 2'd2
  } state_t;

endpackage

// File: rtl/codificador_bcd_seq_if.sv
// Word-level handshake bundle for codificador_bcd_seq: input word/mode with
// valid/ready, converted word plus per-digit error flags with valid/ready.
interface codificador_bcd_seq_if
  import codificador_pkg::*;
#(
  parameter int unsigned DIGITS = 4
);
  localparam int unsigned W = DIGIT_W * DIGITS;

  logic [MODE_W-1:0] mode;
  logic [W-1:0]      in_data;
  logic              in_valid;
  logic              in_ready;
  logic [W-1:0]      out_data;
  logic [DIGITS-1:0] out_err;
  logic              out_valid;
  logic              out_ready;

  modport master (
    output mode, in_data, in_valid, out_ready,
    input  in_ready, out_data, out_err, out_valid
  );

  modport slave (
    input  mode, in_data, in_valid, out_ready,
    output in_ready, out_data, out_err, out_valid
  );

endinterface

// File: rtl/codificador_digito.sv
// Combinational single-digit converter: BCD digit to Excess-3, Gray,
// Aiken 2421 or passthrough; digits above 9 give INVALID_FILL and err_c.
module codificador_digito
  import codificador_pkg::*;
(
  input  logic [DIGIT_W-1:0] digit,
  input  logic [MODE_W-1:0]  mode,
  output logic [DIGIT_W-1:0] code_c,
  output logic               err_c
);

  always_comb begin
    code_c = INVALID_FILL;
    err_c  = 1'b0;
    if (digit > 4'd9) begin
      err_c = 1'b1;
    end else begin
      case (mode)
        MODE_XS3:  code_c = digit + 4'd3;
        MODE_GRAY: code_c = digit ^ (digit >> 1);
        MODE_2421: code_c = (digit <= 4'd4) ? digit : digit + 4'd6;
        default:   code_c = digit;
      endcase
    end
  end

endmodule

// File: rtl/codificador_bcd_seq.sv
// Multi-digit BCD code converter, one digit per clock, valid/ready on both sides.
// Optional saturating error-word counter enabled by CODIFICADOR_ERR_CNT_EN.
module codificador_bcd_seq
  import codificador_pkg::*;
#(
  parameter int unsigned DIGITS = 4
`ifdef CODIFICADOR_ERR_CNT_EN
  ,
  parameter int unsigned ERR_CNT_W = 8
`endif
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  codificador_bcd_seq_if.slave  bus
`ifdef CODIFICADOR_ERR_CNT_EN
  ,
  output logic [ERR_CNT_W-1:0]  err_count
`endif
);

  localparam int unsigned W     = DIGIT_W * DIGITS;
  localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

  state_t            state;
  state_t            state_nxt;
  logic [W-1:0]      word_q;
  logic [MODE_W-1:0] mode_q;
  logic [IDX_W-1:0]  idx;

  logic               accept_c;
  logic               last_c;
  logic [DIGIT_W-1:0] cur_digit_c;
  logic [DIGIT_W-1:0] code_c;
  logic               err_c;

  assign accept_c    = bus.in_ready & bus.in_valid & ~clear;
  assign last_c      = (idx == LAST_IDX);
  assign cur_digit_c = word_q[{idx, 2'b00} +: DIGIT_W];

  codificador_digito u_digito (
    .digit  (cur_digit_c),
    .mode   (mode_q),
    .code_c (code_c),
    .err_c  (err_c)
  );

  // Next-state logic; clear overrides every transition.
  always_comb begin
    state_nxt = state;
    if (clear) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE:    if (accept_c)      state_nxt = S_CONVERT;
        S_CONVERT: if (last_c)        state_nxt = S_HOLD;
        S_HOLD:    if (bus.out_ready) state_nxt = S_IDLE;
        default:                      state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Handshake flags are registered copies of the upcoming state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.in_ready  <= 1'b1;
      bus.out_valid <= 1'b0;
    end else begin
      bus.in_ready  <= (state_nxt == S_IDLE);
      bus.out_valid <= (state_nxt == S_HOLD);
    end
  end

  // Word/mode capture, index counter and result assembly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q       <= '0;
      mode_q       <= MODE_XS3;
      idx          <= '0;
      bus.out_data <= '0;
      bus.out_err  <= '0;
    end else if (clear) begin
      idx          <= '0;
      bus.out_data <= '0;
      bus.out_err  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept_c) begin
            word_q       <= bus.in_data;
            mode_q       <= bus.mode;
            idx          <= '0;
            bus.out_data <= '0;
            bus.out_err  <= '0;
          end
        end
        S_CONVERT: begin
          bus.out_data[{idx, 2'b00} +: DIGIT_W] <= code_c;
          bus.out_err[idx]                      <= err_c;
          if (!last_c) idx <= idx + IDX_W'(1);
        end
        default: ;
      endcase
    end
  end

`ifdef CODIFICADOR_ERR_CNT_EN
  // Counts delivered words carrying at least one invalid digit, saturating.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count <= '0;
    end else if (clear) begin
      err_count <= '0;
    end else if (bus.out_valid && bus.out_ready && (|bus.out_err)
                 && (err_count != {ERR_CNT_W{1'b1}})) begin
      err_count <= err_count + ERR_CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_codificador_bcd_seq.sv
// Directed bench for codificador_bcd_seq (4 digits); covers modes, latency,
// back-pressure, invalid digits, clear/reset aborts and CODIFICADOR_ERR_CNT_EN.
module tb_codificador_bcd_seq;
  import codificador_pkg::*;

  localparam int unsigned DIGITS = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic clear;

  always #5 clk = ~clk;

  codificador_bcd_seq_if #(.DIGITS(DIGITS)) bus ();

`ifdef CODIFICADOR_ERR_CNT_EN
  logic [7:0] err_count;
`endif

  codificador_bcd_seq #(.DIGITS(DIGITS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear),
    .bus   (bus)
`ifdef CODIFICADOR_ERR_CNT_EN
    ,
    .err_count (err_count)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, "_in_ready"},  32'(bus.in_ready),  32'd1);
    check({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
    check({tag, "_out_data"},  32'(bus.out_data),  32'h0);
    check({tag, "_out_err"},   32'(bus.out_err),   32'h0);
  endtask

  // One full word with out_ready high; optionally changes mode mid-conversion.
  task automatic run_word(input string tag, input logic [15:0] din, input logic [1:0] m,
                          input logic [15:0] exp_d, input logic [3:0] exp_e,
                          input bit chg_mode);
    bus.in_data   = din;
    bus.mode      = m;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    check({tag, "_busy"}, 32'(bus.in_ready), 32'd0);
    if (chg_mode) bus.mode = MODE_PASS;
    for (int k = 1; k <= int'(DIGITS); k++) begin
      tick();
      check({tag, "_latency"}, 32'(bus.out_valid), 32'(k == int'(DIGITS)));
    end
    check({tag, "_data"}, 32'(bus.out_data), 32'(exp_d));
    check({tag, "_err"},  32'(bus.out_err),  32'(exp_e));
    tick();
    check({tag, "_done_valid"}, 32'(bus.out_valid), 32'd0);
    check({tag, "_done_ready"}, 32'(bus.in_ready),  32'd1);
  endtask

  initial begin
    rst_n         = 1'b1;
    clear         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.mode      = MODE_XS3;
    bus.in_data   = '0;
    #3 rst_n = 1'b0;
    #1;
    check_idle_zero("reset");
    tick();
    tick();
    rst_n = 1'b1;

    run_word("xs3",  16'h1234, MODE_XS3,  16'h4567, 4'b0000, 1'b0);
    run_word("gray", 16'h0975, MODE_GRAY, 16'h0D47, 4'b0000, 1'b0);

    // 2421 with 10 cycles of back-pressure; in_valid during HOLD must be ignored.
    bus.in_data   = 16'h0595;
    bus.mode      = MODE_2421;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b0;
    tick();
    bus.in_valid = 1'b0;
    for (int k = 0; k < int'(DIGITS); k++) tick();
    bus.in_data  = 16'h1111;
    bus.in_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      check("bp_valid", 32'(bus.out_valid), 32'd1);
      check("bp_data",  32'(bus.out_data),  32'h0BFB);
      check("bp_ready", 32'(bus.in_ready),  32'd0);
      tick();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    check("bp_release_valid", 32'(bus.out_valid), 32'd0);
    check("bp_release_ready", 32'(bus.in_ready),  32'd1);
    tick();
    check("bp_single_hs", 32'(bus.out_valid), 32'd0);

`ifdef CODIFICADOR_ERR_CNT_EN
    check("errcnt_zero", 32'(err_count), 32'd0);
`endif
    run_word("invalid", 16'h12A4, MODE_XS3, 16'h4507, 4'b0010, 1'b0);
    run_word("pass_bad", 16'hF909, MODE_PASS, 16'h0909, 4'b1000, 1'b0);
`ifdef CODIFICADOR_ERR_CNT_EN
    check("errcnt_two", 32'(err_count), 32'd2);
    for (int n = 0; n < 298; n++)
      run_word("sat", 16'h12A4, MODE_XS3, 16'h4507, 4'b0010, 1'b0);
    check("errcnt_sat", 32'(err_count), 32'd255);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("errcnt_clear", 32'(err_count), 32'd0);
`endif

    run_word("modechg", 16'h1234, MODE_XS3, 16'h4567, 4'b0000, 1'b1);

    // Clear on the second CONVERT cycle.
    bus.in_data  = 16'h1234;
    bus.mode     = MODE_XS3;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check_idle_zero("clear");

    // Clear together with in_valid in IDLE: word must not be taken.
    clear        = 1'b1;
    bus.in_valid = 1'b1;
    tick();
    clear        = 1'b0;
    bus.in_valid = 1'b0;
    check("clear_noaccept", 32'(bus.in_ready), 32'd1);
    for (int k = 0; k < int'(DIGITS) + 1; k++) tick();
    check("clear_novalid", 32'(bus.out_valid), 32'd0);

    // Asynchronous reset while holding a result.
    bus.in_data   = 16'h1234;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b0;
    tick();
    bus.in_valid = 1'b0;
    for (int k = 0; k < int'(DIGITS); k++) tick();
    check("hold_before_rst", 32'(bus.out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check_idle_zero("async_rst");
    #2 rst_n = 1'b1;

    run_word("after_abort", 16'h9999, MODE_PASS, 16'h9999, 4'b0000, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
